rf_write_arbiter: RTL and testbench
===================================

RF_WRITE_ARBITER -- requirements
Module: rf_write_arbiter

Interface
REQ-001 The block SHALL take parameter WORD_LENGTH, default 16, data width of one register-file word.
REQ-002 The block SHALL take parameter ID_LENGTH, default 3, register-index width.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 req_valid  input  3  per-requester write request; bit i is requester i.
REQ-006 req_ready  output  3  per-requester acceptance; transfer occurs on a rising edge when valid and ready are both 1.
REQ-007 req_id  input  3*ID_LENGTH  destination index, requester i in bits [i*ID_LENGTH +: ID_LENGTH].
REQ-008 req_data  input  3*WORD_LENGTH  write data, requester i in bits [i*WORD_LENGTH +: WORD_LENGTH].
REQ-009 stall  input  1  when 1, no grant is issued this cycle.
REQ-010 wr_en  output  1  registered write enable to the register-file write port.
REQ-011 wr_reg  output  ID_LENGTH  registered write index.
REQ-012 wr_data  output  WORD_LENGTH  registered write data.
REQ-013 drop_count  output  8  count of consumed writes to index 0, saturating.

Function
REQ-014 Each requester SHALL own a one-entry holding buffer (valid bit, id, data).
REQ-015 req_ready[i] SHALL be 1 when buffer i is empty or is granted this cycle, else 0; req_ready SHALL NOT depend on req_valid.
REQ-016 On accept, buffer i SHALL capture req_id/req_data of requester i and become valid; grant plus accept in the same cycle SHALL leave the buffer valid with the new entry.
REQ-017 Grant SHALL be combinational from buffer valid bits, rr pointer and stall; with stall=0 exactly one valid buffer is granted, searching i = ptr, ptr+1, ptr+2 (mod 3).
REQ-018 On a grant to requester g the buffer SHALL clear (unless reloaded per REQ-016) and ptr SHALL become (g+1) mod 3.
REQ-019 Granted entry with id != 0: next edge SHALL set wr_en=1, wr_reg=id, wr_data=data.
REQ-020 Granted entry with id == 0: entry SHALL be consumed, wr_en=0 next cycle, drop_count +1, holding at 255.
REQ-021 No grant (no valid buffer or stall=1): wr_en SHALL be 0 next cycle; wr_reg/wr_data hold; ptr and buffers hold.
REQ-022 Minimum latency: accept at edge k, grant at edge k+1, wr_en high in the cycle after edge k+1.
REQ-023 Per-requester order SHALL be preserved; no ordering is guaranteed between requesters targeting the same index.
REQ-024 With all three buffers continuously valid and stall=0, grants SHALL rotate 0,1,2,0,... one per cycle; sustained throughput one write per cycle.
REQ-025 stall asserted while a buffer is valid SHALL NOT drop or duplicate the entry.

Reset
REQ-026 While rst=1: buffers empty, ptr=0, wr_en=0, wr_reg=0, wr_data=0, drop_count=0, req_ready=3'b000.
REQ-027 After rst deasserts, req_ready SHALL be 3'b111 in the first cycle.
REQ-028 rst asserted mid-operation SHALL discard all buffered entries without producing a write.

Verification
REQ-029 Single write: req 1 sends id=5, data=16'hBEEF -> wr_en=1, wr_reg=5, wr_data=BEEF exactly two edges after accept, one cycle wide.
REQ-030 Contention: all three valid from reset, ids 1,2,3 -> writes in order 1,2,3 on consecutive cycles; then ptr=0.
REQ-031 Zero index: requester 0 sends id=0 three times -> wr_en never high, drop_count=3; 300 such writes -> drop_count=255.
REQ-032 Stall: buffer valid, stall held 4 cycles -> wr_en=0, req_ready[i]=0 throughout; entry written one edge after stall drops.
REQ-033 Back-to-back: requester 2 valid every cycle, ids 1..6, others idle -> six writes on consecutive cycles, order 1..6.
REQ-034 Reset mid-flight: rst pulsed with all buffers full -> no wr_en pulse, req_ready=3'b111 after release, drop_count=0.

Source files
------------

// File: rtl/rf_write_arbiter.sv
// rtl/rf_write_arbiter.sv - three-requester round-robin arbiter onto one register-file write port
module rf_write_arbiter #(
  parameter int WORD_LENGTH = 16,
  parameter int ID_LENGTH   = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [2:0]               req_valid,
  output logic [2:0]               req_ready,
  input  logic [3*ID_LENGTH-1:0]   req_id,
  input  logic [3*WORD_LENGTH-1:0] req_data,
  input  logic                     stall,
  output logic                     wr_en,
  output logic [ID_LENGTH-1:0]     wr_reg,
  output logic [WORD_LENGTH-1:0]   wr_data,
  output logic [7:0]               drop_count
);

  // One-entry holding buffer per requester
  logic [2:0]             buf_valid_q;
  logic [ID_LENGTH-1:0]   buf_id_q   [3];
  logic [WORD_LENGTH-1:0] buf_data_q [3];

  logic [1:0]             ptr_q, ptr_d;
  logic                   wr_en_q, wr_en_d;
  logic [ID_LENGTH-1:0]   wr_reg_q, wr_reg_d;
  logic [WORD_LENGTH-1:0] wr_data_q, wr_data_d;
  logic [7:0]             drop_q, drop_d;

  logic                   gnt_vld;
  logic [1:0]             gnt_idx;
  logic [2:0]             gnt_oh;
  logic [1:0]             ord1, ord2;
  logic [2:0]             accept;
  logic [ID_LENGTH-1:0]   gnt_id;
  logic [WORD_LENGTH-1:0] gnt_data;

  // Search order starting at the pointer, wrapping modulo 3
  assign ord1 = (ptr_q == 2'd2) ? 2'd0 : ptr_q + 2'd1;
  assign ord2 = (ptr_q == 2'd0) ? 2'd2 : ptr_q - 2'd1;

  // Round-robin grant from buffer valid bits; stall suppresses any grant
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = ptr_q;
    if (!stall) begin
      if (buf_valid_q[ptr_q]) begin
        gnt_vld = 1'b1;
        gnt_idx = ptr_q;
      end else if (buf_valid_q[ord1]) begin
        gnt_vld = 1'b1;
        gnt_idx = ord1;
      end else if (buf_valid_q[ord2]) begin
        gnt_vld = 1'b1;
        gnt_idx = ord2;
      end
    end
  end

  assign gnt_oh   = gnt_vld ? (3'b001 << gnt_idx) : 3'b000;
  assign gnt_id   = buf_id_q[gnt_idx];
  assign gnt_data = buf_data_q[gnt_idx];

  // A buffer can take a new entry when empty or when it drains this cycle;
  // ready is held low throughout reset so nothing is taken in then
  assign req_ready = rst ? 3'b000 : (~buf_valid_q | gnt_oh);
  assign accept    = req_valid & req_ready;

  // Next state of the write port, pointer and drop counter
  always_comb begin
    ptr_d     = ptr_q;
    wr_en_d   = 1'b0;
    wr_reg_d  = wr_reg_q;
    wr_data_d = wr_data_q;
    drop_d    = drop_q;
    if (gnt_vld) begin
      ptr_d = (gnt_idx == 2'd2) ? 2'd0 : gnt_idx + 2'd1;
      if (gnt_id != '0) begin
        wr_en_d   = 1'b1;
        wr_reg_d  = gnt_id;
        wr_data_d = gnt_data;
      end else if (drop_q != 8'hFF) begin
        drop_d = drop_q + 8'd1;
      end
    end
  end

  // Holding buffers: a load wins over a drain so grant+accept keeps the new entry
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_valid_q <= 3'b000;
      for (int i = 0; i < 3; i++) begin
        buf_id_q[i]   <= '0;
        buf_data_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (accept[i]) begin
          buf_valid_q[i] <= 1'b1;
          buf_id_q[i]    <= req_id[i*ID_LENGTH +: ID_LENGTH];
          buf_data_q[i]  <= req_data[i*WORD_LENGTH +: WORD_LENGTH];
        end else if (gnt_oh[i]) begin
          buf_valid_q[i] <= 1'b0;
        end
      end
    end
  end

  // Registered write port, pointer and drop counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q     <= 2'd0;
      wr_en_q   <= 1'b0;
      wr_reg_q  <= '0;
      wr_data_q <= '0;
      drop_q    <= 8'd0;
    end else begin
      ptr_q     <= ptr_d;
      wr_en_q   <= wr_en_d;
      wr_reg_q  <= wr_reg_d;
      wr_data_q <= wr_data_d;
      drop_q    <= drop_d;
    end
  end

  assign wr_en      = wr_en_q;
  assign wr_reg     = wr_reg_q;
  assign wr_data    = wr_data_q;
  assign drop_count = drop_q;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// tb/tb_rf_write_arbiter.sv - directed-vector bench for rf_write_arbiter
module tb_rf_write_arbiter;

  localparam int WL = 16;
  localparam int IL = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [2:0]    req_valid;
  logic [2:0]    req_ready;
  logic [3*IL-1:0] req_id;
  logic [3*WL-1:0] req_data;
  logic          stall;
  logic          wr_en;
  logic [IL-1:0] wr_reg;
  logic [WL-1:0] wr_data;
  logic [7:0]    drop_count;

  int total = 0;
  int bad   = 0;
  int pulses;

  rf_write_arbiter #(.WORD_LENGTH(WL), .ID_LENGTH(IL)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_id(req_id), .req_data(req_data), .stall(stall),
    .wr_en(wr_en), .wr_reg(wr_reg), .wr_data(wr_data), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle 1 time unit after it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = 3'b000;
    stall = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic set_req(input int i, input logic [IL-1:0] id, input logic [WL-1:0] d);
    req_id[i*IL +: IL]   = id;
    req_data[i*WL +: WL] = d;
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 3'b000;
    req_id = '0;
    req_data = '0;
    stall = 1'b0;
    step();
    step();
    // Reset state
    check("rst_wr_en", 32'(wr_en), 32'd0);
    check("rst_wr_reg", 32'(wr_reg), 32'd0);
    check("rst_wr_data", 32'(wr_data), 32'd0);
    check("rst_drop", 32'(drop_count), 32'd0);
    check("rst_ready", 32'(req_ready), 32'b000);
    rst = 1'b0;
    #1;
    check("post_rst_ready", 32'(req_ready), 32'b111);

    // Single write from requester 1
    set_req(1, 3'd5, 16'hBEEF);
    req_valid = 3'b010;
    step();
    req_valid = 3'b000;
    check("single_lat_wr_en", 32'(wr_en), 32'd0);
    step();
    check("single_wr_en", 32'(wr_en), 32'd1);
    check("single_wr_reg", 32'(wr_reg), 32'd5);
    check("single_wr_data", 32'(wr_data), 32'hBEEF);
    step();
    check("single_pulse_end", 32'(wr_en), 32'd0);
    check("single_reg_hold", 32'(wr_reg), 32'd5);

    // Contention from reset: ids 1,2,3, done twice to show pointer returns to 0
    do_reset();
    for (int rep = 0; rep < 2; rep++) begin
      set_req(0, 3'd1, 16'h1000 + 16'(rep));
      set_req(1, 3'd2, 16'h2000 + 16'(rep));
      set_req(2, 3'd3, 16'h3000 + 16'(rep));
      req_valid = 3'b111;
      step();
      req_valid = 3'b000;
      for (int k = 0; k < 3; k++) begin
        step();
        check($sformatf("cont%0d_en%0d", rep, k), 32'(wr_en), 32'd1);
        check($sformatf("cont%0d_reg%0d", rep, k), 32'(wr_reg), 32'(k + 1));
        check($sformatf("cont%0d_data%0d", rep, k), 32'(wr_data), 32'(16'h1000 * (k + 1) + rep));
      end
      step();
      check($sformatf("cont%0d_idle", rep), 32'(wr_en), 32'd0);
    end

    // Zero index drops
    do_reset();
    pulses = 0;
    set_req(0, 3'd0, 16'h5555);
    req_valid = 3'b001;
    for (int k = 0; k < 3; k++) begin
      step();
      if (wr_en) pulses++;
    end
    req_valid = 3'b000;
    step();
    if (wr_en) pulses++;
    check("drop_three", 32'(drop_count), 32'd3);
    req_valid = 3'b001;
    for (int k = 0; k < 300; k++) begin
      step();
      if (wr_en) pulses++;
    end
    req_valid = 3'b000;
    step();
    if (wr_en) pulses++;
    step();
    check("drop_saturate", 32'(drop_count), 32'd255);
    check("drop_no_write", 32'(pulses), 32'd0);

    // Stall holds the entry and keeps ready low
    stall = 1'b1;
    set_req(0, 3'd4, 16'h1234);
    req_valid = 3'b001;
    step();
    req_valid = 3'b000;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("stall_wr_en%0d", k), 32'(wr_en), 32'd0);
      check($sformatf("stall_ready%0d", k), 32'(req_ready[0]), 32'd0);
      if (k < 3) step();
    end
    stall = 1'b0;
    step();
    check("stall_rel_en", 32'(wr_en), 32'd1);
    check("stall_rel_reg", 32'(wr_reg), 32'd4);
    check("stall_rel_data", 32'(wr_data), 32'h1234);
    step();
    check("stall_once", 32'(wr_en), 32'd0);

    // Back-to-back from requester 2, ids 1..6
    set_req(2, 3'd1, 16'hA001);
    req_valid = 3'b100;
    step();
    for (int i = 2; i <= 6; i++) begin
      set_req(2, IL'(i), 16'hA000 + 16'(i));
      step();
      check($sformatf("b2b_en%0d", i - 1), 32'(wr_en), 32'd1);
      check($sformatf("b2b_reg%0d", i - 1), 32'(wr_reg), 32'(i - 1));
      check($sformatf("b2b_data%0d", i - 1), 32'(wr_data), 32'(16'hA000 + i - 1));
    end
    req_valid = 3'b000;
    step();
    check("b2b_en6", 32'(wr_en), 32'd1);
    check("b2b_reg6", 32'(wr_reg), 32'd6);
    step();
    check("b2b_done", 32'(wr_en), 32'd0);

    // Reset mid-flight with all buffers full
    stall = 1'b1;
    set_req(0, 3'd1, 16'h0101);
    set_req(1, 3'd2, 16'h0202);
    set_req(2, 3'd3, 16'h0303);
    req_valid = 3'b111;
    step();
    req_valid = 3'b000;
    check("mid_full_ready", 32'(req_ready), 32'b000);
    rst = 1'b1;
    #1;
    check("mid_rst_ready", 32'(req_ready), 32'b000);
    stall = 1'b0;
    pulses = 0;
    step();
    if (wr_en) pulses++;
    rst = 1'b0;
    #1;
    check("mid_rel_ready", 32'(req_ready), 32'b111);
    for (int k = 0; k < 5; k++) begin
      step();
      if (wr_en) pulses++;
    end
    check("mid_no_write", 32'(pulses), 32'd0);
    check("mid_drop", 32'(drop_count), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
